register_file: RTL and testbench
================================

# register_file

Architectural register file with rename-tag tracking for the out-of-order core. It holds the 32 integer registers and, per register, the RoB index of the youngest in-flight producer. The Dispatcher reads operands and renames destinations; the RoB writes committed results back; a flush clears all pending tags. It is the receiving end of the RoB commit interface (`RF_update_*`) and sits between Dispatcher, RoB and RS/LSB.

## Interface
- `RoB_WIDTH`, 3, log2 of RoB entry count; RoB index width.
- `NON_DEP`, `1 << RoB_WIDTH`, tag value meaning "no pending producer" (width `RoB_WIDTH+1`).

Ports:
- `clk_in` input 1: single clock; all state updates on rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `rdy_in` input 1: low = pause; all state holds.
- `flush_signal` input 1: misprediction flush from RoB.
- `RF_update_en` input 1: RoB commit write valid.
- `RF_update_reg` input 5: committed destination register.
- `RF_update_index` input `RoB_WIDTH`: RoB index of committing entry.
- `RF_update_data` input 32: committed value.
- `rename_en` input 1: Dispatcher issues an instruction with a destination.
- `rename_reg` input 5: destination register being renamed.
- `rename_index` input `RoB_WIDTH`: RoB tail index allocated to it.
- `query_rs1_reg`, `query_rs2_reg` input 5: operand register numbers.
- `query_rs1_data`, `query_rs2_data` output 32: register value (bypassed, see below).
- `query_rs1_dep`, `query_rs2_dep` output `RoB_WIDTH+1`: producer RoB index or `NON_DEP`.

## Operation
- State: `value[0..31]` 32 bits, `dep[0..31]` `RoB_WIDTH+1` bits.
- Reset (`rst_in` high at edge): all `value` = 0, all `dep` = `NON_DEP`. Takes priority over everything, including `rdy_in` low.
- `rdy_in` low and not reset: no state change.
- x0: never written, never renamed; `value[0]` = 0, `dep[0]` = `NON_DEP` permanently. Commits/renames targeting x0 are ignored.
- Commit (`RF_update_en`, reg r != 0): `value[r]` <= `RF_update_data` unconditionally. `dep[r]` <= `NON_DEP` only if `dep[r]` == {1'b0, `RF_update_index`} (a younger rename keeps its tag).
- Rename (`rename_en`, reg r != 0, no flush): `dep[r]` <= {1'b0, `rename_index`}.
- Commit and rename to same register in same cycle: value written, `dep` takes the rename tag (rename wins).
- Flush (`flush_signal` high): all `dep` <= `NON_DEP`; rename ignored; commit still writes `value` (no tag update needed since all cleared).
- Query (combinational, per port, reg q):
  - q == 0: data 0, dep `NON_DEP`.
  - `RF_update_en` and `RF_update_reg` == q and `dep[q]` == {0, `RF_update_index`}: data = `RF_update_data`, dep = `NON_DEP` (same-cycle commit bypass).
  - otherwise: data = `value[q]`, dep = `dep[q]`.
  - Query never reflects a same-cycle rename; Dispatcher queries sources before its own rename, so rs == rd reads the previous producer.

## Timing
- Query: zero-cycle combinational from state and commit inputs.
- Commit/rename/flush: visible on queries the cycle after the edge (except commit bypass, same cycle).
- Outputs after reset: all query data 0, deps `NON_DEP`.
- No handshake; inputs are single-cycle pulses, sampled every enabled edge.
- Reset mid-operation discards all pending tags and values.

## Structure
- Shared package/header: `RoB_WIDTH`, `NON_DEP`, register-count constant (32); shared with RoB, RS, LSB, Dispatcher.
- One sub-module natural: `rf_read_port` (combinational x0/bypass/select logic), instantiated twice for rs1/rs2.

## Test plan
- Reset then query x5, x0 -> data 0, dep `NON_DEP` (8) on both ports.
- Rename x3 -> idx 2; next cycle query x3 -> dep 2; commit x3 idx 2 data 0x1234 -> same cycle query data 0x1234, dep 8; next cycle stored value 0x1234, dep 8.
- Rename x4 -> idx 1, then rename x4 -> idx 5; commit x4 idx 1 data 0xAA -> value 0xAA, dep stays 5.
- Same cycle: commit x7 idx 3 (dep 3) data 0x55 and rename x7 -> idx 6 -> next cycle value 0x55, dep 6.
- Rename x1,x2,x9 to idx 0,1,2; assert `flush_signal` with `rename_en` x10 -> all deps 8, x10 not renamed; commit/rename to x0 -> x0 reads 0/8; `rdy_in` low with rename x11 -> dep unchanged.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants and types for the register file and its RoB/RS/LSB/Dispatcher peers.
//   RoB_WIDTH : log2 of RoB entry count (RoB index width)
//   DEP_W     : rename tag width (RoB index plus the "no producer" bit)
//   NON_DEP   : tag meaning "no pending producer"
//   REG_COUNT : number of architectural integer registers
package register_file_pkg;

  localparam int unsigned RoB_WIDTH = 3;
  localparam int unsigned DEP_W     = RoB_WIDTH + 1;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned DATA_W    = 32;

  typedef logic [DEP_W-1:0]     dep_t;
  typedef logic [RoB_WIDTH-1:0] rob_idx_t;
  typedef logic [REG_AW-1:0]    reg_idx_t;
  typedef logic [DATA_W-1:0]    data_t;

  localparam dep_t NON_DEP = DEP_W'(1 << RoB_WIDTH);

  // RoB commit write-back payload
  typedef struct packed {
    logic     en;
    reg_idx_t rd;
    rob_idx_t index;
    data_t    data;
  } commit_t;

  // Widen a RoB index into a rename tag (top bit clear = real producer)
  function automatic dep_t tag_of(input rob_idx_t idx);
    return {1'b0, idx};
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// Combinational operand read port with same-cycle commit bypass.
//   query_reg  : register number being read
//   values     : stored register values
//   deps       : stored rename tags
//   commit     : RoB commit payload in flight this cycle
//   query_data : operand value (bypassed when the matching commit is in flight)
//   query_dep  : producer tag, or NON_DEP when the value is final
module rf_read_port
  import register_file_pkg::*;
(
  input  reg_idx_t                         query_reg,
  input  logic [REG_COUNT-1:0][DATA_W-1:0] values,
  input  logic [REG_COUNT-1:0][DEP_W-1:0]  deps,
  input  commit_t                          commit,
  output data_t                            query_data,
  output dep_t                             query_dep
);

  dep_t  stored_dep;
  data_t stored_val;
  logic  bypass_hit;

  assign stored_dep = deps[query_reg];
  assign stored_val = values[query_reg];

  // Bypass only when the committing entry is still the register's youngest producer
  assign bypass_hit = commit.en && (commit.rd == query_reg) &&
                      (stored_dep == tag_of(commit.index));

  always_comb begin
    query_data = stored_val;
    query_dep  = stored_dep;
    if (query_reg == REG_AW'(0)) begin
      query_data = '0;
      query_dep  = NON_DEP;
    end else if (bypass_hit) begin
      query_data = commit.data;
      query_dep  = NON_DEP;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural integer register file with per-register rename tags.
//   clk_in, rst_in, rdy_in     : clock, synchronous active-high reset, pause (low = hold)
//   flush_signal               : clears every pending tag, blocks rename
//   RF_update_en/reg/index/data: RoB commit write-back
//   rename_en/reg/index        : Dispatcher destination rename
//   query_rs1_* / query_rs2_*  : combinational operand reads (value + producer tag)
module register_file
  import register_file_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_signal,
  input  logic                 RF_update_en,
  input  logic [REG_AW-1:0]    RF_update_reg,
  input  logic [RoB_WIDTH-1:0] RF_update_index,
  input  logic [DATA_W-1:0]    RF_update_data,
  input  logic                 rename_en,
  input  logic [REG_AW-1:0]    rename_reg,
  input  logic [RoB_WIDTH-1:0] rename_index,
  input  logic [REG_AW-1:0]    query_rs1_reg,
  input  logic [REG_AW-1:0]    query_rs2_reg,
  output logic [DATA_W-1:0]    query_rs1_data,
  output logic [DATA_W-1:0]    query_rs2_data,
  output logic [DEP_W-1:0]     query_rs1_dep,
  output logic [DEP_W-1:0]     query_rs2_dep
);

  logic [REG_COUNT-1:0][DATA_W-1:0] value_q;
  logic [REG_COUNT-1:0][DEP_W-1:0]  dep_q;
  commit_t                          commit;
  logic                             commit_hit;
  logic                             rename_hit;

  assign commit = '{en: RF_update_en, rd: RF_update_reg,
                    index: RF_update_index, data: RF_update_data};

  // x0 is hard-wired, so writes aimed at it are dropped here
  assign commit_hit = RF_update_en && (RF_update_reg != REG_AW'(0));
  assign rename_hit = rename_en && !flush_signal && (rename_reg != REG_AW'(0));

  // Register state; later assignments win: rename over commit tag-clear, flush over both
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value_q[i] <= '0;
        dep_q[i]   <= NON_DEP;
      end
    end else if (rdy_in) begin
      if (commit_hit) begin
        value_q[RF_update_reg] <= RF_update_data;
        // A younger rename of the same register keeps its tag
        if (dep_q[RF_update_reg] == tag_of(RF_update_index)) begin
          dep_q[RF_update_reg] <= NON_DEP;
        end
      end
      if (rename_hit) begin
        dep_q[rename_reg] <= tag_of(rename_index);
      end
      if (flush_signal) begin
        for (int i = 0; i < REG_COUNT; i++) begin
          dep_q[i] <= NON_DEP;
        end
      end
    end
  end

  rf_read_port u_rs1_port (
    .query_reg  (query_rs1_reg),
    .values     (value_q),
    .deps       (dep_q),
    .commit     (commit),
    .query_data (query_rs1_data),
    .query_dep  (query_rs1_dep)
  );

  rf_read_port u_rs2_port (
    .query_reg  (query_rs2_reg),
    .values     (value_q),
    .deps       (dep_q),
    .commit     (commit),
    .query_data (query_rs2_data),
    .query_dep  (query_rs2_dep)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vectors, a behavioural
// model checked every cycle, and hand-computed literal expectations.
module tb_register_file;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_signal;
  logic        RF_update_en;
  logic [4:0]  RF_update_reg;
  logic [2:0]  RF_update_index;
  logic [31:0] RF_update_data;
  logic        rename_en;
  logic [4:0]  rename_reg;
  logic [2:0]  rename_index;
  logic [4:0]  query_rs1_reg;
  logic [4:0]  query_rs2_reg;
  logic [31:0] query_rs1_data;
  logic [31:0] query_rs2_data;
  logic [3:0]  query_rs1_dep;
  logic [3:0]  query_rs2_dep;

  int n_checks;
  int n_fail;
  bit chk_en;

  // Model state: plain values and tags, 8 = no producer
  logic [31:0] m_val [32];
  int          m_dep [32];

  register_file dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .flush_signal    (flush_signal),
    .RF_update_en    (RF_update_en),
    .RF_update_reg   (RF_update_reg),
    .RF_update_index (RF_update_index),
    .RF_update_data  (RF_update_data),
    .rename_en       (rename_en),
    .rename_reg      (rename_reg),
    .rename_index    (rename_index),
    .query_rs1_reg   (query_rs1_reg),
    .query_rs2_reg   (query_rs2_reg),
    .query_rs1_data  (query_rs1_data),
    .query_rs2_data  (query_rs2_data),
    .query_rs1_dep   (query_rs1_dep),
    .query_rs2_dep   (query_rs2_dep)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model of what a read port must return given model state and the in-flight commit
  function automatic logic [31:0] exp_data(input logic [4:0] q);
    if (q == 5'd0) return 32'd0;
    if (RF_update_en && RF_update_reg == q && m_dep[q] == int'(RF_update_index))
      return RF_update_data;
    return m_val[q];
  endfunction

  function automatic logic [31:0] exp_dep(input logic [4:0] q);
    if (q == 5'd0) return 32'd8;
    if (RF_update_en && RF_update_reg == q && m_dep[q] == int'(RF_update_index))
      return 32'd8;
    return 32'(m_dep[q]);
  endfunction

  // Model update on every rising edge
  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'd0;
        m_dep[i] = 8;
      end
    end else if (rdy_in) begin
      int nd [32];
      for (int i = 0; i < 32; i++) nd[i] = m_dep[i];
      if (RF_update_en && RF_update_reg != 5'd0) begin
        m_val[RF_update_reg] = RF_update_data;
        if (m_dep[RF_update_reg] == int'(RF_update_index)) nd[RF_update_reg] = 8;
      end
      if (flush_signal) begin
        for (int i = 0; i < 32; i++) nd[i] = 8;
      end else if (rename_en && rename_reg != 5'd0) begin
        nd[rename_reg] = int'(rename_index);
      end
      for (int i = 0; i < 32; i++) m_dep[i] = nd[i];
    end
  end

  // Compare both read ports against the model every cycle
  always @(negedge clk_in) begin
    if (chk_en) begin
      check("rs1_data", query_rs1_data, exp_data(query_rs1_reg));
      check("rs1_dep", 32'(query_rs1_dep), exp_dep(query_rs1_reg));
      check("rs2_data", query_rs2_data, exp_data(query_rs2_reg));
      check("rs2_dep", 32'(query_rs2_dep), exp_dep(query_rs2_reg));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    flush_signal = 1'b0;
    RF_update_en = 1'b0;
    RF_update_reg = 5'd0;
    RF_update_index = 3'd0;
    RF_update_data = 32'd0;
    rename_en = 1'b0;
    rename_reg = 5'd0;
    rename_index = 3'd0;
  endtask

  task automatic commit(input logic [4:0] r, input logic [2:0] idx, input logic [31:0] d);
    RF_update_en = 1'b1;
    RF_update_reg = r;
    RF_update_index = idx;
    RF_update_data = d;
  endtask

  task automatic rename(input logic [4:0] r, input logic [2:0] idx);
    rename_en = 1'b1;
    rename_reg = r;
    rename_index = idx;
  endtask

  // Hand-computed literal check of both ports at the next falling edge
  task automatic lit(input string name, input logic [4:0] q1, input logic [4:0] q2,
                     input logic [31:0] d1, input logic [3:0] p1,
                     input logic [31:0] d2, input logic [3:0] p2);
    query_rs1_reg = q1;
    query_rs2_reg = q2;
    @(negedge clk_in);
    check({name, "_rs1_data"}, query_rs1_data, d1);
    check({name, "_rs1_dep"}, 32'(query_rs1_dep), 32'(p1));
    check({name, "_rs2_data"}, query_rs2_data, d2);
    check({name, "_rs2_dep"}, 32'(query_rs2_dep), 32'(p2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    chk_en = 1'b0;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    query_rs1_reg = 5'd0;
    query_rs2_reg = 5'd0;
    idle();
    tick();
    tick();
    rst_in = 1'b0;
    chk_en = 1'b1;

    lit("reset", 5'd5, 5'd0, 32'd0, 4'd8, 32'd0, 4'd8);

    // Rename, then commit with same-cycle bypass
    rename(5'd3, 3'd2);
    tick();
    idle();
    lit("ren_x3", 5'd3, 5'd5, 32'd0, 4'd2, 32'd0, 4'd8);
    commit(5'd3, 3'd2, 32'h1234);
    lit("byp_x3", 5'd3, 5'd3, 32'h1234, 4'd8, 32'h1234, 4'd8);
    tick();
    idle();
    lit("st_x3", 5'd3, 5'd0, 32'h1234, 4'd8, 32'd0, 4'd8);

    // Older commit must not clear a younger rename
    rename(5'd4, 3'd1);
    tick();
    rename(5'd4, 3'd5);
    tick();
    idle();
    commit(5'd4, 3'd1, 32'hAA);
    lit("nobyp_x4", 5'd4, 5'd3, 32'd0, 4'd5, 32'h1234, 4'd8);
    tick();
    idle();
    lit("old_x4", 5'd4, 5'd4, 32'hAA, 4'd5, 32'hAA, 4'd5);

    // Commit and rename of the same register in one cycle
    rename(5'd7, 3'd3);
    tick();
    idle();
    commit(5'd7, 3'd3, 32'h55);
    rename(5'd7, 3'd6);
    tick();
    idle();
    lit("cr_x7", 5'd7, 5'd4, 32'h55, 4'd6, 32'hAA, 4'd5);

    // Flush clears every tag and blocks the concurrent rename
    rename(5'd1, 3'd0);
    tick();
    rename(5'd2, 3'd1);
    tick();
    rename(5'd9, 3'd2);
    tick();
    idle();
    lit("pre_fl", 5'd1, 5'd9, 32'd0, 4'd0, 32'd0, 4'd2);
    flush_signal = 1'b1;
    rename(5'd10, 3'd4);
    commit(5'd5, 3'd7, 32'hC0DE);
    tick();
    idle();
    lit("fl_a", 5'd1, 5'd2, 32'd0, 4'd8, 32'd0, 4'd8);
    lit("fl_b", 5'd9, 5'd10, 32'd0, 4'd8, 32'd0, 4'd8);
    lit("fl_c", 5'd7, 5'd5, 32'h55, 4'd8, 32'hC0DE, 4'd8);

    // x0 ignores commits and renames
    commit(5'd0, 3'd0, 32'hDEAD);
    rename(5'd0, 3'd3);
    lit("x0_now", 5'd0, 5'd0, 32'd0, 4'd8, 32'd0, 4'd8);
    tick();
    idle();
    lit("x0_after", 5'd0, 5'd3, 32'd0, 4'd8, 32'h1234, 4'd8);

    // Pause holds all state
    rdy_in = 1'b0;
    rename(5'd11, 3'd5);
    commit(5'd12, 3'd3, 32'h77);
    tick();
    idle();
    rdy_in = 1'b1;
    lit("pause", 5'd11, 5'd12, 32'd0, 4'd8, 32'd0, 4'd8);

    // Reset wins over pause and discards everything
    rename(5'd6, 3'd4);
    tick();
    idle();
    rst_in = 1'b1;
    rdy_in = 1'b0;
    tick();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    lit("rst_a", 5'd3, 5'd6, 32'd0, 4'd8, 32'd0, 4'd8);
    lit("rst_b", 5'd4, 5'd7, 32'd0, 4'd8, 32'd0, 4'd8);

    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
